// File: rtl/pc_sequencer.sv
// Program counter owner and instruction fetch sequencer: issues fetches over a req/ready
// handshake, holds fetched instructions for decode, and applies branch/jump redirects.
module pc_sequencer #(
  parameter int unsigned           ADDR_W     = 32,
  parameter int unsigned           INSTR_W    = 32,
  parameter logic [ADDR_W-1:0]     RESET_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target
);

  typedef enum logic [1:0] {StIdle, StReq, StValid} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
  logic [INSTR_W-1:0] instr_out_q, instr_out_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]  target_aligned;

  // Redirect targets are always word aligned.
  assign target_aligned = branch_target & ~{{(ADDR_W-2){1'b0}}, 2'b11};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_ADDR;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      instr_out_q <= '0;
      instr_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      instr_out_q <= instr_out_d;
      instr_pc_q  <= instr_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    instr_out_d = instr_out_q;
    instr_pc_d  = instr_pc_q;
    case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem_ready) begin
          if (branch_taken || pend_q) begin
            // Returning data belongs to the old path; drop it and refetch.
            pc_d   = branch_taken ? target_aligned : pend_addr_q;
            pend_d = 1'b0;
          end else begin
            instr_out_d = imem_rdata;
            instr_pc_d  = pc_q;
            pc_d        = pc_q + ADDR_W'(4);
            state_d     = StValid;
          end
        end else if (branch_taken) begin
          // Address must stay stable until ready, so remember the redirect.
          pend_d      = 1'b1;
          pend_addr_d = target_aligned;
        end
      end
      StValid: begin
        if (branch_taken) begin
          pc_d    = target_aligned;
          state_d = StReq;
        end else if (!stall) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == StReq);
    imem_addr   = pc_q;
    instr_valid = (state_q == StValid);
    instr_out   = instr_out_q;
    instr_pc    = instr_pc_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic, checked
// against a behavioural fetch model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;

  always #5 clk = ~clk;

  // Memory content is a fixed function of the address.
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  pc_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;

  // Model: 0 = waiting a cycle, 1 = fetch outstanding, 2 = instruction held for decode.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_redir;
  bit          m_has_redir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_mode == 1});
    if (m_mode == 1) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_mode == 2});
  endtask

  task automatic step(input bit br, input logic [31:0] tgt, input bit rdy, input bit stl);
    logic [31:0] t;
    branch_taken  = br;
    branch_target = tgt;
    imem_ready    = rdy;
    stall         = stl;
    t = tgt & 32'hFFFF_FFFC;
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (rdy) begin
          if (br) begin
            m_pc = t;
            m_has_redir = 0;
          end else if (m_has_redir) begin
            m_pc = m_redir;
            m_has_redir = 0;
          end else begin
            sb.push_back('{m_pc, m_pc ^ 32'hA5A5_0000});
            m_pc = m_pc + 32'd4;
            m_mode = 2;
          end
        end else if (br) begin
          m_redir = t;
          m_has_redir = 1;
        end
      end
      default: begin
        if (br) begin
          m_pc = t;
          m_mode = 1;
        end else if (!stl) begin
          m_mode = 1;
        end
      end
    endcase
  endtask

  task automatic cyc(input bit br, input logic [31:0] tgt, input bit rdy, input bit stl);
    @(negedge clk);
    check_outputs();
    step(br, tgt, rdy, stl);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc = 32'h0;
    m_redir = 32'h0;
    m_has_redir = 0;
    sb.delete();
  endtask

  // Drop reset between edges, check immediate effect, then release on a falling edge.
  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 32'h1234_5678, 1'b1, 1'b1);
  endtask

  // Monitor: a fresh instruction appears on each rising edge of instr_valid.
  logic        prev_v = 1'b0;
  logic [31:0] held_pc, held_ins;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v = 1'b0;
    end else begin
      if (instr_valid && !prev_v) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_instr: got pc %h, expected none", instr_pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr_out", instr_out, e.ins);
        end
        held_pc  = instr_pc;
        held_ins = instr_out;
      end else if (instr_valid) begin
        chk("held_pc", instr_pc, held_pc);
        chk("held_instr", instr_out, held_ins);
      end
      prev_v = instr_valid;
    end
  end

  initial begin
    reset_n = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    imem_ready = 1'b0;
    stall = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    reset_n = 1'b1;
    step(1'b1, 32'h1234_5678, 1'b1, 1'b1);  // branch and stall in idle are ignored

    // Sequential fetch and wait states at address 4.
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    // Redirect while the fetch of address 8 is outstanding.
    cyc(0, 0, 0, 0);
    cyc(1, 32'h00FF_0000, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    // Stall hold, then branch beats stall with an unaligned target.
    repeat (4) cyc(0, 0, 0, 1);
    cyc(1, 32'h0000_F103, 0, 1);
    cyc(0, 0, 1, 0);
    // Wrap past the top of the address space.
    cyc(1, 32'hFFFF_FFFC, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    // Same-cycle branch and ready.
    cyc(1, 32'hA000_0008, 1, 0);
    cyc(0, 0, 1, 0);
    // Async reset while fetching address 0x10.
    cyc(1, 32'h0000_0010, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    mid_reset();
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(7) == 0, $urandom, $urandom_range(1) == 1, $urandom_range(2) != 0);
      if (i == 1500) mid_reset();
    end
    cyc(0, 0, 0, 0);
    @(negedge clk);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
